// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port DMEM between core port C and debug/loader port D.
// Latency: gnt at cycle N, done at N+2 (N+1 when the request fails validation).
// Backpressure: one access in flight; requesters hold req until done, losers are re-evaluated in IDLE.
//
// Ports:
//   clk, rst_n                      clock and synchronous active-low reset
//   c_*/d_* req,we,size,addr,wdata  request side (fields stable while req is held)
//   c_*/d_* gnt,done,rdata,err      grant pulse, completion pulse with load data / error flag
//   mem_addr,mem_wdata,mem_rw,
//   mem_wsel,mem_rsel,mem_rdata     DMEM side (mem_rdata registered inside DMEM)
//
// Build option: define DMEM_ARB_RR_EN for round-robin on simultaneous requests;
// left undefined, port C has fixed priority over port D.
module dmem_arbiter #(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [2:0]        c_size,
    input  logic [DATA_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_done,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_size,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rw,
    output logic [1:0]        mem_wsel,
    output logic [2:0]        mem_rsel,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t            state;
    state_t            state_nxt;

    logic              any_req;
    logic              win;
    logic              take;
    logic              sel_we;
    logic [2:0]        sel_size;
    logic [DATA_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              bad_size;
    logic              out_of_range;
    logic              sel_err;

    logic              we_q;
    logic              err_q;
    logic              port_q;
    // The DMEM-facing registers double as the latched addr/wdata/size of the
    // access: they load only for accesses that will really issue, so they hold
    // their last value through error responses and idle periods.
    logic [DATA_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [1:0]        wsel_r;
    logic [2:0]        rsel_r;

`ifdef DMEM_ARB_RR_EN
    logic              last_gnt;
`endif

    // Winner selection and validation of the winner's fields (IDLE only).
    always_comb begin
        any_req = c_req | d_req;
`ifdef DMEM_ARB_RR_EN
        // On a tie, the port that did not win last time goes first.
        win = (c_req && d_req) ? ~last_gnt : d_req;
`else
        win = (c_req && d_req) ? PORT_C : d_req;
`endif
        sel_we    = (win == PORT_D) ? d_we    : c_we;
        sel_size  = (win == PORT_D) ? d_size  : c_size;
        sel_addr  = (win == PORT_D) ? d_addr  : c_addr;
        sel_wdata = (win == PORT_D) ? d_wdata : c_wdata;

        if (sel_we) begin
            bad_size = (sel_size >= 3'b011);
        end else begin
            bad_size = (sel_size == 3'b001) || (sel_size == 3'b110) || (sel_size == 3'b111);
        end
        out_of_range = ((sel_addr >> MEM_AW) != '0);
        sel_err      = (sel_addr[1:0] != 2'b00) || bad_size || out_of_range;
        take         = (state == IDLE) && any_req;
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state. Failed validation skips ISSUE so DMEM is never touched.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = sel_err ? RESP : ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs. Everything is gated by rst_n so a reset cycle
    // produces no grant, no write and no completion.
    always_comb begin
        c_gnt   = rst_n && take && (win == PORT_C);
        d_gnt   = rst_n && take && (win == PORT_D);
        c_done  = rst_n && (state == RESP) && (port_q == PORT_C);
        d_done  = rst_n && (state == RESP) && (port_q == PORT_D);
        c_err   = c_done && err_q;
        d_err   = d_done && err_q;
        c_rdata = (c_done && !we_q && !err_q) ? mem_rdata : '0;
        d_rdata = (d_done && !we_q && !err_q) ? mem_rdata : '0;
        mem_rw  = (state == ISSUE) && we_q && rst_n;
    end

    // Request latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            port_q   <= PORT_C;
            addr_r   <= '0;
            wdata_r  <= '0;
            wsel_r   <= '0;
            rsel_r   <= '0;
`ifdef DMEM_ARB_RR_EN
            last_gnt <= PORT_D;
`endif
        end else if (take) begin
            we_q   <= sel_we;
            err_q  <= sel_err;
            port_q <= win;
            if (!sel_err) begin
                addr_r  <= sel_addr;
                wdata_r <= sel_wdata;
                wsel_r  <= sel_size[1:0];
                rsel_r  <= sel_size;
            end
`ifdef DMEM_ARB_RR_EN
            last_gnt <= win;
`endif
        end
    end

    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign mem_wsel  = wsel_r;
    assign mem_rsel  = rsel_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: DMEM stub, transaction-level model, directed stimulus.
// Latency: not applicable (bench).
// Backpressure: requesters hold req until their done pulse, then drop it.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_req, c_we, d_req, d_we;
    logic [2:0]  c_size, d_size;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_done, c_err, d_gnt, d_done, d_err;
    logic [31:0] c_rdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rw;
    logic [1:0]  mem_wsel;
    logic [2:0]  mem_rsel;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(32), .MEM_AW(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
        .mem_wsel(mem_wsel), .mem_rsel(mem_rsel), .mem_rdata(mem_rdata)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- DMEM stub: synchronous write, registered read ----------------
    logic [31:0] dm [int unsigned];

    function automatic logic [31:0] dm_word(input logic [31:0] a);
        return dm.exists(a >> 2) ? dm[a >> 2] : 32'h0;
    endfunction

    initial begin
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            if (mem_rw) begin
                case (mem_wsel)
                    2'b00:   dm[mem_addr >> 2] = {dm_word(mem_addr)[31:8],  mem_wdata[7:0]};
                    2'b01:   dm[mem_addr >> 2] = {dm_word(mem_addr)[31:16], mem_wdata[15:0]};
                    default: dm[mem_addr >> 2] = mem_wdata;
                endcase
            end
            case (mem_rsel)
                3'b000:  mem_rdata <= {{24{dm_word(mem_addr)[7]}}, dm_word(mem_addr)[7:0]};
                3'b100:  mem_rdata <= {24'h0, dm_word(mem_addr)[7:0]};
                3'b101:  mem_rdata <= {16'h0, dm_word(mem_addr)[15:0]};
                default: mem_rdata <= dm_word(mem_addr);
            endcase
        end
    end

    // ---------------- Transaction-level model ----------------
    // Byte-addressed memory image plus "when is the arbiter free again".
    logic [7:0]  mm [int unsigned];
    int          free_at = 0;
    bit          m_last  = 1'b1;        // 0 = C, 1 = D
    bit          exp_port [int];
    bit          exp_err  [int];
    logic [31:0] exp_rd   [int];
    logic [31:0] exp_wa   [int];
    logic [31:0] exp_wd   [int];
    int          exp_wn   [int];        // bytes written

    function automatic logic [7:0] mm_byte(input logic [31:0] a);
        return mm.exists(a) ? mm[a] : 8'h00;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] v;
        v = {mm_byte(a + 3), mm_byte(a + 2), mm_byte(a + 1), mm_byte(a)};
        case (sz)
            3'b000:  return (v[7:0] >= 8'h80) ? (32'hFFFF_FF00 + v[7:0]) : v[7:0];
            3'b100:  return v % 256;
            3'b101:  return v % 65536;
            default: return v;
        endcase
    endfunction

    bit          eg_c, eg_d, m_w, m_we, m_e;
    logic [2:0]  m_sz;
    logic [31:0] m_a, m_wd;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("quiet_in_reset", {27'h0, c_gnt, d_gnt, c_done, d_done, mem_rw}, 32'h0);
                exp_port.delete(); exp_err.delete(); exp_rd.delete();
                exp_wa.delete(); exp_wd.delete(); exp_wn.delete();
                free_at = cyc + 1;
                m_last  = 1'b1;
            end else begin
                eg_c = 1'b0;
                eg_d = 1'b0;
                if (cyc >= free_at && (c_req || d_req)) begin
                    if (c_req && d_req) begin
`ifdef DMEM_ARB_RR_EN
                        m_w = (m_last == 1'b1) ? 1'b0 : 1'b1;
`else
                        m_w = 1'b0;
`endif
                    end else begin
                        m_w = d_req;
                    end
                    eg_c = (m_w == 1'b0);
                    eg_d = (m_w == 1'b1);
                    m_we = m_w ? d_we : c_we;
                    m_sz = m_w ? d_size : c_size;
                    m_a  = m_w ? d_addr : c_addr;
                    m_wd = m_w ? d_wdata : c_wdata;
                    m_e  = (m_a % 4 != 0) || (m_a >= 32'h0010_0000) ||
                           (m_we ? (m_sz > 2) : (m_sz == 1 || m_sz == 6 || m_sz == 7));
                    exp_port[cyc + (m_e ? 1 : 2)] = m_w;
                    exp_err [cyc + (m_e ? 1 : 2)] = m_e;
                    exp_rd  [cyc + (m_e ? 1 : 2)] = (m_we || m_e) ? 32'h0 : model_load(m_a, m_sz);
                    if (m_we && !m_e) begin
                        exp_wa[cyc + 1] = m_a;
                        exp_wd[cyc + 1] = m_wd;
                        exp_wn[cyc + 1] = (m_sz == 0) ? 1 : (m_sz == 1) ? 2 : 4;
                    end
                    free_at = cyc + (m_e ? 2 : 3);
                    m_last  = m_w;
                end
                chk("c_gnt", {31'h0, c_gnt}, {31'h0, eg_c});
                chk("d_gnt", {31'h0, d_gnt}, {31'h0, eg_d});

                if (exp_port.exists(cyc)) begin
                    chk("c_done", {31'h0, c_done}, {31'h0, !exp_port[cyc]});
                    chk("d_done", {31'h0, d_done}, {31'h0, exp_port[cyc]});
                    chk("rdata", exp_port[cyc] ? d_rdata : c_rdata, exp_rd[cyc]);
                    chk("err", {31'h0, exp_port[cyc] ? d_err : c_err}, {31'h0, exp_err[cyc]});
                    exp_port.delete(cyc); exp_err.delete(cyc); exp_rd.delete(cyc);
                end else begin
                    chk("no_done", {30'h0, c_done, d_done}, 32'h0);
                end

                if (exp_wa.exists(cyc)) begin
                    chk("mem_rw", {31'h0, mem_rw}, 32'h1);
                    chk("mem_addr", mem_addr, exp_wa[cyc]);
                    chk("mem_wdata", mem_wdata, exp_wd[cyc]);
                    for (int b = 0; b < exp_wn[cyc]; b++)
                        mm[exp_wa[cyc] + b] = exp_wd[cyc][8*b +: 8];
                    exp_wa.delete(cyc); exp_wd.delete(cyc); exp_wn.delete(cyc);
                end else begin
                    chk("mem_rw_quiet", {31'h0, mem_rw}, 32'h0);
                end
            end
        end
    end

    // ---------------- Stimulus ----------------
    task automatic access(input bit p, input bit we, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output bit er, output int lat);
        int t0;
        bit got;
        @(posedge clk); #1;
        if (!p) begin c_req = 1; c_we = we; c_size = sz; c_addr = a; c_wdata = wd; end
        else    begin d_req = 1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd; end
        t0 = -100; got = 0; rd = 0; er = 0; lat = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (p ? d_gnt : c_gnt) t0 = cyc;
            if (p ? d_done : c_done) begin
                got = 1;
                rd  = p ? d_rdata : c_rdata;
                er  = p ? d_err : c_err;
                lat = cyc - t0;
            end
        end
        if (!got) chk("access_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        c_req = 0;
        d_req = 0;
    endtask

    task automatic run(input string name, input bit p, input bit we, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] x_rd, input bit x_er, input int x_lat);
        logic [31:0] rd;
        bit er;
        int lat;
        access(p, we, sz, a, wd, rd, er, lat);
        chk({name, "_rdata"}, rd, x_rd);
        chk({name, "_err"}, {31'h0, er}, {31'h0, x_er});
        chk({name, "_lat"}, lat, x_lat);
    endtask

    int order [4];
    int exp_order [4];
    int ng, nd;

    initial begin
        rst_n = 0;
        c_req = 0; c_we = 0; c_size = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_size = 0; d_addr = 0; d_wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_c_rdata", c_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_err", {30'h0, c_err, d_err}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_sel", {27'h0, mem_wsel, mem_rsel}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1;

        // Both ports hold requests across four accesses.
`ifdef DMEM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        order = '{9, 9, 9, 9};
        @(posedge clk); #1;
        c_req = 1; c_we = 0; c_size = 3'b010; c_addr = 32'h100;
        d_req = 1; d_we = 0; d_size = 3'b010; d_addr = 32'h104;
        ng = 0; nd = 0;
        for (int i = 0; i < 60 && nd < 4; i++) begin
            @(negedge clk);
            if (c_gnt && ng < 4) begin order[ng] = 0; ng++; end
            if (d_gnt && ng < 4) begin order[ng] = 1; ng++; end
            if (c_done || d_done) nd++;
        end
        if (nd < 4) chk("arb_timeout", nd, 4);
        @(posedge clk); #1;
        c_req = 0; d_req = 0;
        for (int k = 0; k < 4; k++) chk($sformatf("arb_order%0d", k), order[k], exp_order[k]);

        run("c_sw100",   0, 1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 2);
        run("c_lw100",   0, 0, 3'b010, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, 2);
        run("c_sb104",   0, 1, 3'b000, 32'h0000_0104, 32'h0000_0080, 32'h0, 0, 2);
        run("c_lb104",   0, 0, 3'b000, 32'h0000_0104, 32'h0,         32'hFFFF_FF80, 0, 2);
        run("c_lbu104",  0, 0, 3'b100, 32'h0000_0104, 32'h0,         32'h0000_0080, 0, 2);
        run("d_lw102",   1, 0, 3'b010, 32'h0000_0102, 32'h0,         32'h0, 1, 1);
        run("d_lw_oor",  1, 0, 3'b010, 32'h0010_0000, 32'h0,         32'h0, 1, 1);
        run("c_sw3fc",   0, 1, 3'b010, 32'h0000_03FC, 32'h0BAD_F00D, 32'h0, 0, 2);
        run("c_lw3fc",   0, 0, 3'b010, 32'h0000_03FC, 32'h0,         32'h0BAD_F00D, 0, 2);
        run("c_swtop",   0, 1, 3'b010, 32'h000F_FFFC, 32'hCAFE_1234, 32'h0, 0, 2);
        run("c_lwtop",   0, 0, 3'b010, 32'h000F_FFFC, 32'h0,         32'hCAFE_1234, 0, 2);
        run("c_ld_sz6",  0, 0, 3'b110, 32'h0000_0100, 32'h0,         32'h0, 1, 1);
        run("d_st_sz3",  1, 1, 3'b011, 32'h0000_0100, 32'h1111_2222, 32'h0, 1, 1);
        run("c_lw100b",  0, 0, 3'b010, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, 2);
        run("d_sw108",   1, 1, 3'b010, 32'h0000_0108, 32'h5555_AAAA, 32'h0, 0, 2);
        run("c_lhu108",  0, 0, 3'b101, 32'h0000_0108, 32'h0,         32'h0000_AAAA, 0, 2);

        // Reset lands in the ISSUE cycle of a store: the store must be lost.
        run("c_sw200",   0, 1, 3'b010, 32'h0000_0200, 32'h1111_1111, 32'h0, 0, 2);
        @(posedge clk); #1;
        c_req = 1; c_we = 1; c_size = 3'b010; c_addr = 32'h200; c_wdata = 32'h2222_2222;
        @(negedge clk);
        chk("rst_case_gnt", {31'h0, c_gnt}, 32'h1);
        @(posedge clk); #1;
        rst_n = 0;
        @(negedge clk);
        chk("rst_case_rw", {31'h0, mem_rw}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1;
        c_req = 0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_case_no_done", {31'h0, c_done}, 32'h0);
        end
        run("c_lw200",   0, 0, 3'b010, 32'h0000_0200, 32'h0,         32'h1111_1111, 0, 2);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
